// File: rtl/ram_sdp_ctrl.sv
// Simple-dual-port RAM with byte enables, in-order read responses and a post-reset clear.
// Define RAM_WR_FWD_EN to return write-first data on a same-address read/write collision.
module ram_sdp_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wr_valid,
   output logic                             wr_ready,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
   input  logic                             rd_valid,
   output logic                             rd_ready,
   input  logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic                             init_done
);
   localparam int LENGTH = 2**ADDR_WIDTH;
   localparam int NBE    = DATA_WIDTH/BYTE_WIDTH;
   localparam int DEPTH  = RD_LATENCY + 1;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int PW     = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(LENGTH - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   cnt;
   logic [DATA_WIDTH-1:0] mem [LENGTH];
   logic [DATA_WIDTH-1:0] rbuf [DEPTH];
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] push_d;
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [CW-1:0]         fcnt;
   logic [CW-1:0]         outstanding;
   logic                  wr_fire;
   logic                  rd_fire;
   logic                  rsp_fire;
   logic                  push_v;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign wr_fire   = wr_valid & wr_ready;
   assign rd_fire   = rd_valid & rd_ready;
   assign rsp_fire  = rsp_valid & rsp_ready;
   // Credit check uses only registered state, so rsp_ready never reaches rd_ready.
   assign rd_ready  = (state == RUN) & (outstanding < CW'(DEPTH));
   assign rsp_valid = (fcnt != '0);
   assign rsp_data  = rbuf[rptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= INIT;
         cnt       <= '0;
         init_done <= 1'b0;
         wr_ready  <= 1'b0;
      end else begin
         unique case (state)
            INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= RUN;
                  init_done <= 1'b1;
                  wr_ready  <= 1'b1;
               end
            end
            RUN: begin
               state <= RUN;
            end
            default: state <= INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && state == INIT) begin
         mem[cnt[ADDR_WIDTH-1:0]] <= '0;
      end else if (rst_n && wr_fire) begin
         for (int i = 0; i < NBE; i++) begin
            if (wr_be[i])
               mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                  wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

`ifdef RAM_WR_FWD_EN
   always_comb begin
      rd_word = mem[rd_addr];
      for (int i = 0; i < NBE; i++) begin
         if (wr_fire && (wr_addr == rd_addr) && wr_be[i])
            rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
               wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end
`else
   assign rd_word = mem[rd_addr];
`endif

   // The last latency stage is the response buffer entry itself.
   generate
      if (RD_LATENCY == 1) begin : g_lat1
         assign push_v = rd_fire;
         assign push_d = rd_word;
      end else begin : g_lat2
         logic                  pv;
         logic [DATA_WIDTH-1:0] pd;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               pv <= 1'b0;
               pd <= '0;
            end else begin
               pv <= rd_fire;
               pd <= rd_word;
            end
         end
         assign push_v = pv;
         assign push_d = pd;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr        <= '0;
         rptr        <= '0;
         fcnt        <= '0;
         outstanding <= '0;
         for (int i = 0; i < DEPTH; i++) rbuf[i] <= '0;
      end else begin
         if (push_v) begin
            rbuf[wptr] <= push_d;
            wptr       <= nxt(wptr);
         end
         if (rsp_fire) rptr <= nxt(rptr);
         fcnt        <= fcnt + CW'(push_v) - CW'(rsp_fire);
         outstanding <= outstanding + CW'(rd_fire) - CW'(rsp_fire);
      end
   end

endmodule

// File: tb/tb_ram_sdp_ctrl.sv
// Bench for ram_sdp_ctrl: two instances (read latency 1 and 2), directed
// vectors, hand-written corner sequences and randomized traffic against a model.
module tb_ram_sdp_ctrl;
   localparam int AW  = 4;
   localparam int DW  = 16;
   localparam int LEN = 16;

   logic          clk = 1'b0;
   logic          rst_n     [2];
   logic          wr_valid  [2];
   logic          wr_ready  [2];
   logic [AW-1:0] wr_addr   [2];
   logic [DW-1:0] wr_data   [2];
   logic [1:0]    wr_be     [2];
   logic          rd_valid  [2];
   logic          rd_ready  [2];
   logic [AW-1:0] rd_addr   [2];
   logic          rsp_valid [2];
   logic          rsp_ready [2];
   logic [DW-1:0] rsp_data  [2];
   logic          init_done [2];

   always #5 clk = ~clk;

   ram_sdp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RD_LATENCY(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n[0]),
      .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_addr(wr_addr[0]),
      .wr_data(wr_data[0]), .wr_be(wr_be[0]),
      .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_addr(rd_addr[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
      .init_done(init_done[0]));

   ram_sdp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RD_LATENCY(2)) u_lat2 (
      .clk(clk), .rst_n(rst_n[1]),
      .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_addr(wr_addr[1]),
      .wr_data(wr_data[1]), .wr_be(wr_be[1]),
      .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_addr(rd_addr[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
      .init_done(init_done[1]));

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    be;
      logic [DW-1:0] exp;
   } vec_t;

   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   int            cur = 0;
   int            lat = 1;
   bit            running [2];
   logic [DW-1:0] mm [2][LEN];
   logic [DW-1:0] expq [$];
   logic [DW-1:0] rsp_dat [$];
   int            rsp_cyc [$];
   logic [DW-1:0] last_rsp;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (lat%0d): got %0h expected %0h", name, cur + 1, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [1:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < 2; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   // One clock with model bookkeeping: responses are checked against the
   // queue of accepted reads, which is also the expected outstanding count.
   task automatic step(input int k);
      logic [DW-1:0] rv;
      if (running[k]) begin
         check("rd_ready", rd_ready[k], logic'(expq.size() < lat + 1));
         check("wr_ready", wr_ready[k], 1);
      end
      if (rsp_valid[k] && rsp_ready[k]) begin
         if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected (lat%0d): got %0h expected none", k + 1, rsp_data[k]);
         end else begin
            check("rsp_data", rsp_data[k], expq.pop_front());
         end
         last_rsp = rsp_data[k];
         rsp_dat.push_back(rsp_data[k]);
         rsp_cyc.push_back(cyc);
      end
      if (rd_valid[k] && rd_ready[k]) begin
         rv = mm[k][rd_addr[k]];
`ifdef RAM_WR_FWD_EN
         if (wr_valid[k] && wr_ready[k] && wr_addr[k] == rd_addr[k])
            rv = merge(rv, wr_data[k], wr_be[k]);
`endif
         expq.push_back(rv);
      end
      if (wr_valid[k] && wr_ready[k])
         mm[k][wr_addr[k]] = merge(mm[k][wr_addr[k]], wr_data[k], wr_be[k]);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic reset_and_init(input int k);
      int n;
      int bad;
      int stale;
      wr_valid[k] = 1'b0;
      rd_valid[k] = 1'b0;
      rst_n[k] = 1'b0;
      running[k] = 1'b0;
      @(posedge clk);
      #1;
      expq.delete();
      for (int i = 0; i < LEN; i++) mm[k][i] = '0;
      check("rst_wr_ready", wr_ready[k], 0);
      check("rst_rd_ready", rd_ready[k], 0);
      check("rst_rsp_valid", rsp_valid[k], 0);
      check("rst_rsp_data", rsp_data[k], 0);
      check("rst_init_done", init_done[k], 0);
      rst_n[k] = 1'b1;
      rsp_ready[k] = 1'b1;
      n = 0;
      bad = 0;
      stale = 0;
      while (!init_done[k] && n < 40) begin
         if (wr_ready[k] || rd_ready[k]) bad++;
         if (rsp_valid[k]) stale++;
         step(k);
         n++;
      end
      check("init_cycles", n, 16);
      check("ready_in_init", bad, 0);
      check("stale_rsp", stale, 0);
      check("run_wr_ready", wr_ready[k], 1);
      check("run_rd_ready", rd_ready[k], 1);
      running[k] = 1'b1;
   endtask

   task automatic drain(input int k);
      int n;
      rsp_ready[k] = 1'b1;
      n = 0;
      while (expq.size() > 0 && n < 30) begin
         step(k);
         n++;
      end
      check("drain", expq.size(), 0);
   endtask

   task automatic do_write(input int k, input int a, input logic [DW-1:0] d, input logic [1:0] be);
      wr_valid[k] = 1'b1;
      wr_addr[k] = AW'(a);
      wr_data[k] = d;
      wr_be[k] = be;
      step(k);
      wr_valid[k] = 1'b0;
   endtask

   task automatic read_word(input int k, input int a);
      int n;
      rd_valid[k] = 1'b1;
      rd_addr[k] = AW'(a);
      n = 0;
      while (!rd_ready[k] && n < 20) begin
         step(k);
         n++;
      end
      check("rd_accept_wait", n < 20, 1);
      step(k);
      rd_valid[k] = 1'b0;
      drain(k);
   endtask

   task automatic run_dut(input int k);
      vec_t tbl [6];
      int   n;
      int   acc;
      int   nz;
      tbl[0] = '{addr: 4'd3, data: 16'hABCD, be: 2'b11, exp: 16'hABCD};
      tbl[1] = '{addr: 4'd3, data: 16'h1234, be: 2'b01, exp: 16'hAB34};
      tbl[2] = '{addr: 4'd7, data: 16'hFFFF, be: 2'b10, exp: 16'hFF00};
      tbl[3] = '{addr: 4'd7, data: 16'h0055, be: 2'b01, exp: 16'hFF55};
      tbl[4] = '{addr: 4'd3, data: 16'h0000, be: 2'b00, exp: 16'hAB34};
      tbl[5] = '{addr: 4'd0, data: 16'hBEEF, be: 2'b11, exp: 16'hBEEF};
      cur = k;
      lat = k + 1;

      reset_and_init(k);

      rsp_dat.delete();
      rsp_ready[k] = 1'b1;
      for (int a = 0; a < LEN; a++) begin
         rd_valid[k] = 1'b1;
         rd_addr[k] = AW'(a);
         step(k);
      end
      rd_valid[k] = 1'b0;
      drain(k);
      nz = 0;
      foreach (rsp_dat[i]) if (rsp_dat[i] != 0) nz++;
      check("clear_count", rsp_dat.size(), 16);
      check("clear_nonzero", nz, 0);

      for (int i = 0; i < 6; i++) begin
         do_write(k, int'(tbl[i].addr), tbl[i].data, tbl[i].be);
         read_word(k, int'(tbl[i].addr));
         check("be_vec", last_rsp, tbl[i].exp);
      end

      rsp_ready[k] = 1'b1;
      rd_valid[k] = 1'b1;
      rd_addr[k] = 4'd3;
      check("lat_rd_ready", rd_ready[k], 1);
      step(k);
      rd_valid[k] = 1'b0;
      n = 1;
      while (!rsp_valid[k] && n < 10) begin
         step(k);
         n++;
      end
      check("rd_latency", n, lat);
      drain(k);
      check("lat_data", last_rsp, 16'hAB34);

      for (int a = 0; a < 8; a++) do_write(k, a, 16'(16'h100 + a), 2'b11);
      rsp_dat.delete();
      rsp_cyc.delete();
      rsp_ready[k] = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd_valid[k] = 1'b1;
         rd_addr[k] = AW'(a);
         check("stream_rd_ready", rd_ready[k], 1);
         step(k);
      end
      rd_valid[k] = 1'b0;
      drain(k);
      check("stream_count", rsp_dat.size(), 8);
      if (rsp_dat.size() == 8) begin
         check("stream_back2back", rsp_cyc[7] - rsp_cyc[0], 7);
         for (int i = 0; i < 8; i++) check("stream_data", rsp_dat[i], 16'h100 + i);
      end

      rsp_dat.delete();
      rsp_ready[k] = 1'b0;
      rd_valid[k] = 1'b1;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         rd_addr[k] = AW'(acc);
         if (rd_ready[k]) acc++;
         step(k);
      end
      check("bp_accepted", acc, lat + 1);
      check("bp_rd_ready", rd_ready[k], 0);
      for (int c = 0; c < 3; c++) begin
         check("bp_hold_valid", rsp_valid[k], 1);
         check("bp_hold_data", rsp_data[k], 16'h0100);
         step(k);
      end
      rd_valid[k] = 1'b0;
      drain(k);
      check("bp_rsp_count", rsp_dat.size(), lat + 1);
      foreach (rsp_dat[i]) check("bp_order", rsp_dat[i], 16'h100 + i);
      check("bp_rd_ready_back", rd_ready[k], 1);

      do_write(k, 5, 16'h1111, 2'b11);
      rsp_ready[k] = 1'b1;
      wr_valid[k] = 1'b1;
      wr_addr[k] = 4'd5;
      wr_data[k] = 16'h2222;
      wr_be[k] = 2'b11;
      rd_valid[k] = 1'b1;
      rd_addr[k] = 4'd5;
      check("coll_rd_ready", rd_ready[k], 1);
      step(k);
      wr_valid[k] = 1'b0;
      rd_valid[k] = 1'b0;
      drain(k);
`ifdef RAM_WR_FWD_EN
      check("collision", last_rsp, 16'h2222);
`else
      check("collision", last_rsp, 16'h1111);
`endif
      read_word(k, 5);
      check("coll_after", last_rsp, 16'h2222);

      for (int c = 0; c < 200; c++) begin
         wr_valid[k] = 1'($urandom_range(0, 1));
         wr_addr[k] = AW'($urandom_range(0, LEN - 1));
         wr_data[k] = 16'($urandom);
         wr_be[k] = 2'($urandom_range(0, 3));
         rd_valid[k] = 1'($urandom_range(0, 1));
         rd_addr[k] = AW'($urandom_range(0, LEN - 1));
         rsp_ready[k] = ($urandom_range(0, 3) != 0);
         step(k);
      end
      wr_valid[k] = 1'b0;
      rd_valid[k] = 1'b0;
      drain(k);

      rsp_ready[k] = 1'b0;
      rd_valid[k] = 1'b1;
      rd_addr[k] = 4'd5;
      acc = 0;
      n = 0;
      while (acc < 2 && n < 10) begin
         if (rd_ready[k]) acc++;
         step(k);
         n++;
      end
      rd_valid[k] = 1'b0;
      check("midop_accepted", acc, 2);
      reset_and_init(k);
      read_word(k, 5);
      check("reclear_addr5", last_rsp, 16'h0000);
      read_word(k, 0);
      check("reclear_addr0", last_rsp, 16'h0000);
      running[k] = 1'b0;
      rst_n[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0;
         wr_valid[k] = 1'b0;
         wr_addr[k] = '0;
         wr_data[k] = '0;
         wr_be[k] = '0;
         rd_valid[k] = 1'b0;
         rd_addr[k] = '0;
         rsp_ready[k] = 1'b0;
         running[k] = 1'b0;
      end
      last_rsp = '0;
      @(posedge clk);
      #1;
      run_dut(0);
      run_dut(1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
